// File: rtl/rr_arb_wrr.sv
// Weighted round-robin arbiter: registered one-hot ack, bursts of weight+1.
// Define RR_ARB_WRR_HIPRI_EN to add the hipri port and a strict-priority class 0.
module rr_arb_wrr #(
  parameter int NUM_OF_INPUT = 32,
  parameter int INPUT_NBITS  = $clog2(NUM_OF_INPUT),
  parameter int WEIGHT_NBITS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_OF_INPUT-1:0]              req,
  input  logic                                 en,
`ifdef RR_ARB_WRR_HIPRI_EN
  input  logic [NUM_OF_INPUT-1:0]              hipri,
`endif
  input  logic [NUM_OF_INPUT*WEIGHT_NBITS-1:0] weight,
  output logic [NUM_OF_INPUT-1:0]              ack,
  output logic [INPUT_NBITS-1:0]               sel,
  output logic                                 gnt
);

  localparam int N  = NUM_OF_INPUT;
  localparam int IW = INPUT_NBITS;
  localparam int W  = WEIGHT_NBITS;

  typedef enum logic {IDLE, OWN} state_t;

  state_t         state, state_n;
  logic [IW-1:0]  arb, arb_n;
  logic [IW-1:0]  harb, harb_n;
  logic           cls_hi, cls_hi_n;
  logic [W-1:0]   cnt, cnt_n;
  logic [N-1:0]   ack_n;
  logic [IW-1:0]  sel_n;
  logic           gnt_n;

  logic [N-1:0]   hreq;
  logic [N-1:0]   lreq;
  logic [IW:0]    hp;
  logic [IW:0]    lp;
  logic [IW-1:0]  hold;
  logic           cont;
  logic           take;
  logic [IW-1:0]  win;

`ifdef RR_ARB_WRR_HIPRI_EN
  assign hreq = req & hipri;
`else
  assign hreq = '0;
`endif
  assign lreq = req & ~hreq;

  // {found, index}: first request after p, wrapping, p itself last
  function automatic logic [IW:0] pick(
    input logic [N-1:0]  r,
    input logic [IW-1:0] p
  );
    logic [IW:0] res;
    int k;
    res = '0;
    for (int i = 1; i <= N; i++) begin
      k = int'(p) + i;
      if (k >= N) k = k - N;
      if (!res[IW] && r[k]) res = {1'b1, k[IW-1:0]};
    end
    return res;
  endfunction

  assign hp   = pick(hreq, harb);
  assign lp   = pick(lreq, arb);
  assign hold = cls_hi ? harb : arb;

  // a low-class burst yields as soon as any high-class request shows up
  assign cont = (state == OWN) &&
                (cls_hi ? hreq[harb]
                        : (req[arb] && (hreq == '0)));

  always_comb begin
    state_n  = state;
    arb_n    = arb;
    harb_n   = harb;
    cls_hi_n = cls_hi;
    cnt_n    = cnt;
    sel_n    = sel;
    ack_n    = '0;
    gnt_n    = 1'b0;
    take     = 1'b0;
    win      = '0;
    if (en) begin
      if (cont) begin
        take  = 1'b1;
        win   = hold;
        cnt_n = cnt - W'(1);
        if (cnt == W'(1)) state_n = IDLE;
      end else if (hp[IW]) begin
        take     = 1'b1;
        win      = hp[IW-1:0];
        harb_n   = win;
        cls_hi_n = 1'b1;
      end else if (lp[IW]) begin
        take     = 1'b1;
        win      = lp[IW-1:0];
        arb_n    = win;
        cls_hi_n = 1'b0;
      end else begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      if (take && !cont) begin
        cnt_n   = weight[int'(win)*W +: W];
        state_n = (cnt_n != '0) ? OWN : IDLE;
      end
      if (take) begin
        ack_n = N'(1) << win;
        sel_n = win;
        gnt_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      arb    <= '0;
      harb   <= '0;
      cls_hi <= 1'b0;
      cnt    <= '0;
      ack    <= '0;
      sel    <= '0;
      gnt    <= 1'b0;
    end else begin
      state  <= state_n;
      arb    <= arb_n;
      harb   <= harb_n;
      cls_hi <= cls_hi_n;
      cnt    <= cnt_n;
      ack    <= ack_n;
      sel    <= sel_n;
      gnt    <= gnt_n;
    end
  end

endmodule

// File: tb/tb_rr_arb_wrr.sv
// Directed bench for rr_arb_wrr (N=32, W=4).
// Hipri scenario is built only when RR_ARB_WRR_HIPRI_EN is defined.
module tb_rr_arb_wrr;

  localparam int N  = 32;
  localparam int IW = 5;
  localparam int W  = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic           en;
  logic [N-1:0]   hipri;
  logic [N*W-1:0] wt;
  logic [N-1:0]   ack;
  logic [IW-1:0]  sel;
  logic           gnt;

  int total;
  int bad;

  rr_arb_wrr #(
    .NUM_OF_INPUT(N),
    .INPUT_NBITS (IW),
    .WEIGHT_NBITS(W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .en    (en),
`ifdef RR_ARB_WRR_HIPRI_EN
    .hipri (hipri),
`endif
    .weight(wt),
    .ack   (ack),
    .sel   (sel),
    .gnt   (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N+IW:0] grant_of(input int i);
    return {1'b1, IW'(i), N'(1) << i};
  endfunction

  function automatic logic [N+IW:0] idle_of(input int s);
    return {1'b0, IW'(s), N'(0)};
  endfunction

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    en    = 1'b1;
    hipri = '0;
    wt    = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair_setup(input int w3);
    req = '0;
    req[3] = 1'b1;
    req[7] = 1'b1;
    wt[3*W +: W] = W'(w3);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({gnt, sel, ack} !== idle_of(0)) begin
      bad++;
      $display("FAIL reset: got %h want %h", {gnt, sel, ack}, idle_of(0));
    end
    tick();
    total++;
    if ({gnt, sel, ack} !== idle_of(0)) begin
      bad++;
      $display("FAIL reset_noreq: got %h want %h", {gnt, sel, ack}, idle_of(0));
    end
  endtask

  task automatic test_plain_rr();
    do_reset();
    req = '1;
    for (int c = 0; c < 33; c++) begin
      tick();
      total++;
      if ({gnt, sel, ack} !== grant_of((c + 1) % N)) begin
        bad++;
        $display("FAIL plain_rr[%0d]: got %h want %h", c, {gnt, sel, ack}, grant_of((c + 1) % N));
      end
    end
  endtask

  task automatic test_burst();
    int e[8] = '{3, 3, 3, 7, 3, 3, 3, 7};
    do_reset();
    pair_setup(2);
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if ({gnt, sel, ack} !== grant_of(e[c])) begin
        bad++;
        $display("FAIL burst[%0d]: got %h want %h", c, {gnt, sel, ack}, grant_of(e[c]));
      end
    end
    req = '0;
    tick();
    total++;
    if ({gnt, sel, ack} !== idle_of(7)) begin
      bad++;
      $display("FAIL burst_noreq: got %h want %h", {gnt, sel, ack}, idle_of(7));
    end
  endtask

  task automatic test_drop();
    int e[4] = '{3, 3, 3, 7};
    do_reset();
    pair_setup(2);
    tick();
    req[3] = 1'b0;
    tick();
    total++;
    if ({gnt, sel, ack} !== grant_of(7)) begin
      bad++;
      $display("FAIL drop_switch: got %h want %h", {gnt, sel, ack}, grant_of(7));
    end
    req[3] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if ({gnt, sel, ack} !== grant_of(e[c])) begin
        bad++;
        $display("FAIL drop_rewin[%0d]: got %h want %h", c, {gnt, sel, ack}, grant_of(e[c]));
      end
    end
  endtask

  task automatic test_stall();
    int e[3] = '{3, 3, 7};
    do_reset();
    pair_setup(2);
    tick();
    en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if ({gnt, sel, ack} !== idle_of(3)) begin
        bad++;
        $display("FAIL stall[%0d]: got %h want %h", c, {gnt, sel, ack}, idle_of(3));
      end
    end
    en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({gnt, sel, ack} !== grant_of(e[c])) begin
        bad++;
        $display("FAIL stall_resume[%0d]: got %h want %h", c, {gnt, sel, ack}, grant_of(e[c]));
      end
    end
  endtask

  task automatic test_weight_change();
    int e[5] = '{3, 3, 7, 3, 7};
    do_reset();
    pair_setup(2);
    tick();
    wt[3*W +: W] = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if ({gnt, sel, ack} !== grant_of(e[c])) begin
        bad++;
        $display("FAIL wchange[%0d]: got %h want %h", c, {gnt, sel, ack}, grant_of(e[c]));
      end
    end
  endtask

  task automatic test_async_reset();
    int e[3] = '{5, 0, 5};
    do_reset();
    pair_setup(2);
    tick();
    tick();
    rst = 1'b1;
    #1;
    total++;
    if ({gnt, sel, ack} !== idle_of(0)) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", {gnt, sel, ack}, idle_of(0));
    end
    req = '0;
    wt  = '0;
    req[0] = 1'b1;
    req[5] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({gnt, sel, ack} !== grant_of(e[c])) begin
        bad++;
        $display("FAIL post_reset[%0d]: got %h want %h", c, {gnt, sel, ack}, grant_of(e[c]));
      end
    end
  endtask

`ifdef RR_ARB_WRR_HIPRI_EN
  task automatic test_hipri();
    do_reset();
    req[3] = 1'b1;
    wt[3*W +: W] = W'(5);
    tick();
    tick();
    req[10]   = 1'b1;
    hipri[10] = 1'b1;
    tick();
    total++;
    if ({gnt, sel, ack} !== grant_of(10)) begin
      bad++;
      $display("FAIL hipri_preempt: got %h want %h", {gnt, sel, ack}, grant_of(10));
    end
    req[10] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if ({gnt, sel, ack} !== grant_of(3)) begin
        bad++;
        $display("FAIL hipri_back[%0d]: got %h want %h", c, {gnt, sel, ack}, grant_of(3));
      end
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = '0;
    en    = 1'b0;
    hipri = '0;
    wt    = '0;
    test_reset();
    test_plain_rr();
    test_burst();
    test_drop();
    test_stall();
    test_weight_change();
    test_async_reset();
`ifdef RR_ARB_WRR_HIPRI_EN
    test_hipri();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
